cfg_bus_master: RTL
===================

Name: cfg_bus_master

Overview:
Initiator end of the cartridge register bus (select / read_rq / write_rq / ack). Accepts byte-serial commands from the host link (USB/UART RX FIFO side), drives single register read or write cycles, and returns a status byte plus read data on a TX byte stream. Lets the PC-side tool program cart config and CIC registers.

Parameters:
TIMEOUT, 255, WAIT-state cycles allowed for i_ack before abort (1..65535)

Ports:
i_clk  in  1  clock
i_reset  in  1  reset
i_rx_valid  in  1  RX byte available
i_rx_data  in  8  RX byte
o_rx_ready  out  1  byte consumed when i_rx_valid && o_rx_ready
o_tx_valid  out  1  TX byte valid
o_tx_data  out  8  TX byte
i_tx_ready  in  1  TX byte accepted when o_tx_valid && i_tx_ready
o_select  out  1  bus select, held REQ through WAIT
o_read_rq  out  1  one-cycle read strobe
o_write_rq  out  1  one-cycle write strobe
o_address  out  32  bus address
o_data  out  32  write data
i_ack  in  1  responder acknowledge
i_data  in  32  read data, valid with i_ack

Behaviour:
- Reset: i_reset, synchronous, active-high, clock i_clk. All outputs 0. State IDLE. Counters and shift registers cleared. Partial command discarded. Reset in any state, including WAIT or mid-RESP, aborts without completing the bus cycle or response.
- Command format, all multi-byte fields MSB first:
  - Write: 0x57, addr[4], data[4]
  - Read: 0x52, addr[4]
- States: IDLE, ADDR, DATA, REQ, WAIT, RESP. CSUM is added only under the optional feature.
- o_rx_ready = 1 only in IDLE, ADDR, DATA (and CSUM). It is 0 in all other states.
- IDLE, on accepted byte:
  - 0x52 or 0x57: latch opcode, go to ADDR.
  - Any other byte: status = 0x02, go to RESP with a 1-byte response. No bus activity.
- ADDR: shift 4 bytes into o_address via a 2-bit byte counter. After the 4th byte: write goes to DATA; read goes to REQ.
- DATA: shift 4 bytes into o_data, then go to REQ.
- REQ: exactly one cycle.
  - o_select = 1.
  - o_write_rq = 1 for write, o_read_rq = 1 for read.
  - Never both strobes at once.
  - i_ack ignored in this cycle.
  - Go to WAIT with cycle counter = 1.
- WAIT: o_select = 1, strobes 0.
  - If i_ack: latch i_data (read only), status = 0x00, go to RESP.
  - Else if counter == TIMEOUT: status = 0x01, read data = 0x00000000, go to RESP.
  - Else counter++.
  - Ack in the same cycle the counter reaches TIMEOUT counts as success.
  - o_select drops the cycle after leaving WAIT.
- i_ack outside WAIT is ignored.
- o_address and o_data hold their values until overwritten by the next command.
- RESP:
  - Write or bad opcode: status byte only.
  - Read: status, then data[31:24], [23:16], [15:8], [7:0].
  - o_tx_valid stays high and o_tx_data stays stable until handshake. One byte per handshake.
  - A handshake on the last byte drops o_tx_valid and returns to IDLE in the next cycle.
  - RX input is not consumed during RESP.
- No pipelining: one outstanding bus cycle maximum.
- Max bus-cycle latency REQ to RESP is TIMEOUT+1 cycles.

Optional Feature:
- Macro: CFG_BUS_MASTER_CHECKSUM_EN.
- Defined:
  - Each command carries a trailing byte in state CSUM, accepted after the final addr/data byte.
  - The byte must equal the XOR of all preceding command bytes, opcode included.
  - Match: proceed to REQ.
  - Mismatch: status = 0x03, 1-byte response, no bus cycle.
- Undefined: no CSUM state, no trailing byte, status 0x03 never produced.

Test Plan:
1. Write: RX 57 00 00 00 00 00 00 00 1F; responder acks 1 cycle after strobe -> one-cycle o_write_rq with o_address=0x00000000, o_data=0x0000001F; o_select high 2 cycles; TX 00.
2. Read: RX 52 00 00 00 04; ack with i_data=0x000000A5 -> one-cycle o_read_rq at address 0x4; TX 00 00 00 00 A5.
3. Timeout (TIMEOUT=8): read, never ack -> o_select high 9 cycles (REQ + 8 WAIT), then low; TX 01 00 00 00 00. Repeat with ack on WAIT cycle 8 -> TX 00 plus data.
4. Bad opcode: RX 41 then 52 00 00 00 00 -> TX 02, no o_select; 0x52 is decoded as a new opcode and a normal read completes.
5. Backpressure: read response with i_tx_ready low 10 cycles at each byte -> o_tx_valid held, o_tx_data stable, o_rx_ready low, exactly 5 bytes delivered.
6. Reset mid-command: RX 57 12 34, assert i_reset 1 cycle -> all outputs 0, IDLE; a subsequent full write completes with the new address/data only. With CFG_BUS_MASTER_CHECKSUM_EN: RX 52 00 00 00 04 56 -> read proceeds; final byte 00 -> TX 03.

Source files
------------

// File: rtl/cfg_bus_master.sv
// Host-link command decoder driving single read/write cycles on the cartridge register bus.
// Optional trailing-XOR checksum byte on every command when CFG_BUS_MASTER_CHECKSUM_EN is defined.
module cfg_bus_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_rx_ready,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  output logic        o_select,
  output logic        o_read_rq,
  output logic        o_write_rq,
  output logic [31:0] o_address,
  output logic [31:0] o_data,
  input  logic        i_ack,
  input  logic [31:0] i_data
);

  localparam logic [7:0]  OP_READ    = 8'h52;
  localparam logic [7:0]  OP_WRITE   = 8'h57;
  localparam logic [7:0]  ST_OK      = 8'h00;
  localparam logic [7:0]  ST_TIMEOUT = 8'h01;
  localparam logic [7:0]  ST_BADOP   = 8'h02;
  localparam logic [15:0] TIMEOUT_C  = 16'(TIMEOUT);

`ifdef CFG_BUS_MASTER_CHECKSUM_EN
  localparam logic [7:0]  ST_BADSUM  = 8'h03;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_CSUM, S_REQ, S_WAIT, S_RESP} state_t;
  localparam state_t S_LAST = S_CSUM;
`else
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_REQ, S_WAIT, S_RESP} state_t;
  localparam state_t S_LAST = S_REQ;
`endif

  state_t      state;
  logic        is_wr;
  logic [1:0]  byte_cnt;
  logic [15:0] wait_cnt;
  logic [31:0] rdata;
  logic [2:0]  tx_left;
  logic        rx_fire;
  logic        tx_fire;
  logic        start_req;
`ifdef CFG_BUS_MASTER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign rx_fire = i_rx_valid && o_rx_ready;
  assign tx_fire = o_tx_valid && i_tx_ready;

  // The last accepted command byte launches the bus cycle.
`ifdef CFG_BUS_MASTER_CHECKSUM_EN
  assign start_req = rx_fire && (state == S_CSUM) && (i_rx_data == csum);
`else
  assign start_req = rx_fire && (byte_cnt == 2'd3) &&
                     ((state == S_DATA) || ((state == S_ADDR) && !is_wr));
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= S_IDLE;
      is_wr      <= 1'b0;
      byte_cnt   <= 2'd0;
      wait_cnt   <= 16'd0;
      rdata      <= 32'd0;
      tx_left    <= 3'd0;
      o_rx_ready <= 1'b0;
      o_tx_valid <= 1'b0;
      o_tx_data  <= 8'd0;
      o_select   <= 1'b0;
      o_read_rq  <= 1'b0;
      o_write_rq <= 1'b0;
      o_address  <= 32'd0;
      o_data     <= 32'd0;
`ifdef CFG_BUS_MASTER_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      o_read_rq  <= 1'b0;
      o_write_rq <= 1'b0;
      case (state)
        S_IDLE: begin
          o_rx_ready <= 1'b1;
          if (rx_fire) begin
            byte_cnt <= 2'd0;
`ifdef CFG_BUS_MASTER_CHECKSUM_EN
            csum     <= i_rx_data;
`endif
            if (i_rx_data == OP_READ || i_rx_data == OP_WRITE) begin
              is_wr <= (i_rx_data == OP_WRITE);
              state <= S_ADDR;
            end else begin
              o_rx_ready <= 1'b0;
              o_tx_valid <= 1'b1;
              o_tx_data  <= ST_BADOP;
              tx_left    <= 3'd0;
              state      <= S_RESP;
            end
          end
        end
        S_ADDR: begin
          if (rx_fire) begin
            o_address <= {o_address[23:0], i_rx_data};
            byte_cnt  <= byte_cnt + 2'd1;
`ifdef CFG_BUS_MASTER_CHECKSUM_EN
            csum      <= csum ^ i_rx_data;
`endif
            if (byte_cnt == 2'd3)
              state <= is_wr ? S_DATA : S_LAST;
          end
        end
        S_DATA: begin
          if (rx_fire) begin
            o_data   <= {o_data[23:0], i_rx_data};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef CFG_BUS_MASTER_CHECKSUM_EN
            csum     <= csum ^ i_rx_data;
`endif
            if (byte_cnt == 2'd3)
              state <= S_LAST;
          end
        end
`ifdef CFG_BUS_MASTER_CHECKSUM_EN
        S_CSUM: begin
          if (rx_fire && i_rx_data != csum) begin
            o_rx_ready <= 1'b0;
            o_tx_valid <= 1'b1;
            o_tx_data  <= ST_BADSUM;
            tx_left    <= 3'd0;
            state      <= S_RESP;
          end
        end
`endif
        S_REQ: begin
          wait_cnt <= 16'd1;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // Ack wins over timeout when both land in the same cycle.
          if (i_ack || wait_cnt == TIMEOUT_C) begin
            o_select   <= 1'b0;
            o_tx_valid <= 1'b1;
            o_tx_data  <= i_ack ? ST_OK : ST_TIMEOUT;
            tx_left    <= is_wr ? 3'd0 : 3'd4;
            state      <= S_RESP;
            if (!i_ack)
              rdata <= 32'd0;
            else if (!is_wr)
              rdata <= i_data;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_RESP: begin
          if (tx_fire) begin
            if (tx_left == 3'd0) begin
              o_tx_valid <= 1'b0;
              o_tx_data  <= 8'd0;
              o_rx_ready <= 1'b1;
              state      <= S_IDLE;
            end else begin
              o_tx_data <= rdata[31:24];
              rdata     <= {rdata[23:0], 8'h00};
              tx_left   <= tx_left - 3'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      if (start_req) begin
        o_rx_ready <= 1'b0;
        o_select   <= 1'b1;
        o_read_rq  <= !is_wr;
        o_write_rq <= is_wr;
        state      <= S_REQ;
      end
    end
  end

endmodule
